// File: rtl/vedic_pkg.sv
// Shared widths and FSM state type for the sequential Vedic multiplier.
package vedic_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned FULL_W = 2 * HALF_W;
  localparam int unsigned PROD_W = 2 * FULL_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL0 = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_MUL3 = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/vedic_16x16.sv
// Combinational 16x16 Urdhva-Tiryakbhyam multiplier built recursively
// from 2x2 cells: each level forms four half products and recombines them.
module vedic_16x16
  import vedic_pkg::*;
(
  input  logic [HALF_W-1:0]   i_x,
  input  logic [HALF_W-1:0]   i_y,
  output logic [2*HALF_W-1:0] o_p
);

  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic q0, q1, q2, q3, s1, c1, s2, c2;
    q0 = x[0] & y[0];
    q1 = x[1] & y[0];
    q2 = x[0] & y[1];
    q3 = x[1] & y[1];
    s1 = q1 ^ q2;
    c1 = q1 & q2;
    s2 = q3 ^ c1;
    c2 = q3 & c1;
    return {c2, s2, s1, q0};
  endfunction

  // {hh,ll} is exact because ll never reaches 2^(2k); cross terms go in at shift k.
  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, lh, hl, hh;
    ll = vm2(x[1:0], y[1:0]);
    lh = vm2(x[1:0], y[3:2]);
    hl = vm2(x[3:2], y[1:0]);
    hh = vm2(x[3:2], y[3:2]);
    return {hh, ll} + {2'b0, lh, 2'b0} + {2'b0, hl, 2'b0};
  endfunction

  function automatic logic [15:0] vm8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ll, lh, hl, hh;
    ll = vm4(x[3:0], y[3:0]);
    lh = vm4(x[3:0], y[7:4]);
    hl = vm4(x[7:4], y[3:0]);
    hh = vm4(x[7:4], y[7:4]);
    return {hh, ll} + {4'b0, lh, 4'b0} + {4'b0, hl, 4'b0};
  endfunction

  logic [15:0] w_ll, w_lh, w_hl, w_hh;

  always_comb begin
    w_ll = vm8(i_x[7:0],  i_y[7:0]);
    w_lh = vm8(i_x[7:0],  i_y[15:8]);
    w_hl = vm8(i_x[15:8], i_y[7:0]);
    w_hh = vm8(i_x[15:8], i_y[15:8]);
    o_p  = {w_hh, w_ll} + {8'b0, w_lh, 8'b0} + {8'b0, w_hl, 8'b0};
  end

endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// 32x32 unsigned multiplier that time-shares one 16x16 Vedic core over
// four cycles, with valid/ready handshakes on both sides and abort.
module vedic_mul_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int unsigned HALF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FULL_W-1:0] a,
  input  logic [FULL_W-1:0] b,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] c,
  output logic              busy
);

  state_t              r_state;
  logic [FULL_W-1:0]   r_a;
  logic [FULL_W-1:0]   r_b;
  logic [PROD_W-1:0]   r_acc;

  logic [HALF_W-1:0]   w_ha;
  logic [HALF_W-1:0]   w_hb;
  logic [2*HALF_W-1:0] w_pp;
  logic [PROD_W-1:0]   w_pp_sh;
  state_t              w_mul_next;

  // Half-select muxes: MUL2/MUL3 use a's upper half, MUL1/MUL3 use b's upper half.
  always_comb begin
    w_ha = r_a[HALF_W-1:0];
    w_hb = r_b[HALF_W-1:0];
    if (r_state == ST_MUL2 || r_state == ST_MUL3) w_ha = r_a[FULL_W-1:HALF_W];
    if (r_state == ST_MUL1 || r_state == ST_MUL3) w_hb = r_b[FULL_W-1:HALF_W];
  end

  vedic_16x16 u_core (
    .i_x (w_ha),
    .i_y (w_hb),
    .o_p (w_pp)
  );

  always_comb begin
    w_pp_sh    = '0;
    w_mul_next = ST_IDLE;
    case (r_state)
      ST_MUL0: begin
        w_pp_sh    = PROD_W'(w_pp);
        w_mul_next = ST_MUL1;
      end
      ST_MUL1: begin
        w_pp_sh    = PROD_W'(w_pp) << HALF_W;
        w_mul_next = ST_MUL2;
      end
      ST_MUL2: begin
        w_pp_sh    = PROD_W'(w_pp) << HALF_W;
        w_mul_next = ST_MUL3;
      end
      ST_MUL3: begin
        w_pp_sh    = PROD_W'(w_pp) << FULL_W;
        w_mul_next = ST_DONE;
      end
      default: begin
        w_pp_sh    = '0;
        w_mul_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // abort outranks in_valid so nothing is accepted in an abort cycle
          if (!abort && in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_state <= ST_MUL0;
          end
        end
        ST_MUL0, ST_MUL1, ST_MUL2, ST_MUL3: begin
          if (abort) begin
            r_acc   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_acc   <= r_acc + w_pp_sh;
            r_state <= w_mul_next;
          end
        end
        ST_DONE: begin
          if (abort || out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, keeping in_valid/out_ready off the path to c.
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    out_valid = (r_state == ST_DONE);
    c         = (r_state == ST_DONE) ? r_acc : '0;
  end

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Self-checking bench for vedic_mul_seq_ctrl against a plain a*b reference.
module tb_vedic_mul_seq_ctrl;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        abort     = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a         = '0;
  logic [31:0] b         = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [63:0] c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vedic_mul_seq_ctrl #(.HALF_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .busy      (busy)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 in IDLE; ends at posedge+1 in the cycle after the DONE transfer.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input int stall,
                       output logic hs, output int lat, output logic [63:0] cv,
                       output logic stable_ok, output logic zero_ok);
    hs = 1'b0; lat = 0; cv = '0; stable_ok = 1'b1; zero_ok = 1'b1;
    a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    hs = in_ready;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      if (c !== 64'd0) zero_ok = 1'b0;
      if (lat >= 20) break;
      step();
      lat++;
    end
    if (out_valid) begin
      cv = c;
      for (int i = 0; i < stall; i++) begin
        step();
        @(negedge clk);
        if (c !== cv || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) stable_ok = 1'b0;
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 100", {in_ready, out_valid, busy});
    end
    n_cmp++;
    if (c !== 64'd0) begin
      n_bad++; $display("FAIL reset_c: got %h expected 0", c);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic hs, st, zo; int lat; logic [63:0] cv;
    do_op(32'd3, 32'd5, 0, hs, lat, cv, st, zo);
    n_cmp++;
    if (hs !== 1'b1) begin n_bad++; $display("FAIL basic_first_handshake: got %b expected 1", hs); end
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_cmp++;
    if (cv !== 64'h000000000000000F) begin n_bad++; $display("FAIL basic_c: got %h expected 000000000000000f", cv); end
    n_cmp++;
    if (zo !== 1'b1) begin n_bad++; $display("FAIL basic_c_zero: got %b expected 1", zo); end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_T6: got %b expected 1", in_ready); end
    step();
  endtask

  task automatic test_max();
    logic hs, st, zo; int lat; logic [63:0] cv;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, hs, lat, cv, st, zo);
    n_cmp++;
    if (cv !== 64'hFFFFFFFE00000001) begin n_bad++; $display("FAIL max_c: got %h expected fffffffe00000001", cv); end
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL max_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_stall();
    logic hs, st, zo; int lat; logic [63:0] cv;
    do_op(32'h00010000, 32'h00010000, 3, hs, lat, cv, st, zo);
    n_cmp++;
    if (cv !== 64'h0000000100000000) begin n_bad++; $display("FAIL stall_c: got %h expected 0000000100000000", cv); end
    n_cmp++;
    if (st !== 1'b1) begin n_bad++; $display("FAIL stall_hold: got %b expected 1", st); end
  endtask

  task automatic test_abort_mul2();
    logic hs, st, zo; int lat; logic [63:0] cv; logic seen;
    a = 32'h12345678; b = 32'h9ABCDEF0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_bad++; $display("FAIL abort_idle_next: got %b expected 100", {in_ready, out_valid, busy});
    end
    seen = 1'b0;
    step();
    repeat (8) begin
      @(negedge clk);
      seen |= out_valid;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_valid: got %b expected 0", seen); end
    do_op(32'd2, 32'd7, 0, hs, lat, cv, st, zo);
    n_cmp++;
    if (cv !== 64'd14) begin n_bad++; $display("FAIL abort_next_c: got %h expected e", cv); end
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL abort_next_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_reset_mid();
    logic hs, st, zo; int lat; logic [63:0] cv;
    a = $urandom; b = $urandom; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_bad++; $display("FAIL rstmid_flags: got %b expected 100", {in_ready, out_valid, busy});
    end
    n_cmp++;
    if (c !== 64'd0) begin n_bad++; $display("FAIL rstmid_c: got %h expected 0", c); end
    step();
    rst_n = 1'b1;
    do_op(32'h00010000, 32'h3, 0, hs, lat, cv, st, zo);
    n_cmp++;
    if (hs !== 1'b1) begin n_bad++; $display("FAIL rstmid_handshake: got %b expected 1", hs); end
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL rstmid_latency: got %0d expected 5", lat); end
    n_cmp++;
    if (cv !== 64'h30000) begin n_bad++; $display("FAIL rstmid_c: got %h expected 30000", cv); end
  endtask

  task automatic test_hold_in_valid();
    logic [31:0] a0, b0; logic ready_low;
    a0 = $urandom; b0 = $urandom;
    a = a0; b = b0; in_valid = 1'b1;
    step();
    ready_low = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom;
      @(negedge clk);
      if (in_ready !== 1'b0) ready_low = 1'b0;
      step();
    end
    a = $urandom; b = $urandom;
    @(negedge clk);
    n_cmp++;
    if (ready_low !== 1'b1) begin n_bad++; $display("FAIL hold_ready_low: got %b expected 1", ready_low); end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid: got %b expected 1", out_valid); end
    n_cmp++;
    if (c !== ref_mul(a0, b0)) begin n_bad++; $display("FAIL hold_c: got %h expected %h", c, ref_mul(a0, b0)); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_back_idle: got %b expected 0", busy); end
    step();
  endtask

  task automatic test_abort_idle();
    a = 32'd5; b = 32'd5; abort = 1'b1; in_valid = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle_no_accept: got %b expected 0", busy); end
    step();
  endtask

  task automatic test_abort_done();
    a = 32'd9; b = 32'd11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || c !== 64'd99) begin
      n_bad++; $display("FAIL abort_done_result: got valid=%b c=%h expected valid=1 c=63", out_valid, c);
    end
    abort = 1'b1; out_ready = 1'b1;
    step();
    abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100 || c !== 64'd0) begin
      n_bad++; $display("FAIL abort_done_idle: got %b c=%h expected 100 c=0", {in_ready, out_valid, busy}, c);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic hs, st, zo; int lat; logic [63:0] cv; logic [31:0] x, y;
    for (int n = 0; n < 6; n++) begin
      x = $urandom; y = $urandom;
      do_op(x, y, 0, hs, lat, cv, st, zo);
      n_cmp++;
      if (hs !== 1'b1) begin n_bad++; $display("FAIL b2b_accept[%0d]: got %b expected 1", n, hs); end
      n_cmp++;
      if (cv !== ref_mul(x, y)) begin n_bad++; $display("FAIL b2b_c[%0d]: got %h expected %h", n, cv, ref_mul(x, y)); end
    end
  endtask

  task automatic test_random();
    logic hs, st, zo; int lat; logic [63:0] cv; logic [31:0] x, y; int stall;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       x = 32'd0;
        1:       x = 32'hFFFFFFFF;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      stall = int'($urandom_range(0, 3));
      do_op(x, y, stall, hs, lat, cv, st, zo);
      n_cmp++;
      if (cv !== ref_mul(x, y)) begin n_bad++; $display("FAIL rand_c[%0d]: got %h expected %h", n, cv, ref_mul(x, y)); end
      n_cmp++;
      if (lat !== 5) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d expected 5", n, lat); end
      n_cmp++;
      if (hs !== 1'b1) begin n_bad++; $display("FAIL rand_accept[%0d]: got %b expected 1", n, hs); end
      n_cmp++;
      if (st !== 1'b1) begin n_bad++; $display("FAIL rand_hold[%0d]: got %b expected 1", n, st); end
      n_cmp++;
      if (zo !== 1'b1) begin n_bad++; $display("FAIL rand_c_zero[%0d]: got %b expected 1", n, zo); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_stall();
    test_abort_mul2();
    test_reset_mid();
    test_hold_in_valid();
    test_abort_idle();
    test_abort_done();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vedic_mul_seq_ctrl.md
VEDIC_MUL_SEQ_CTRL -- requirements
Module: vedic_mul_seq_ctrl

Interface
REQ-001 Parameter: HALF_W, 16, half operand width; only the value 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair a/b is valid.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 a  input  32  unsigned multiplicand.
REQ-007 b  input  32  unsigned multiplier.
REQ-008 abort  input  1  synchronous cancel of the current operation.
REQ-009 out_valid  output  1  product c is valid.
REQ-010 out_ready  input  1  consumer takes c this cycle.
REQ-011 c  output  64  unsigned product a*b.
REQ-012 busy  output  1  high in any state except IDLE.

Function
REQ-013 The block SHALL compute a 32x32 product by time-sharing one 16x16 multiplier over four cycles.
REQ-014 The FSM SHALL have states IDLE, MUL0, MUL1, MUL2, MUL3 and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; in IDLE, in_valid=1 latches a/b, clears the accumulator and moves to MUL0.
REQ-016 Partial products SHALL be: MUL0 a[15:0]*b[15:0] at shift 0; MUL1 a[15:0]*b[31:16] at shift 16; MUL2 a[31:16]*b[15:0] at shift 16; MUL3 a[31:16]*b[31:16] at shift 32.
REQ-017 Each MULn state SHALL add its shifted 32-bit partial product into a 64-bit accumulator at the end of that cycle, then advance to the next state; MUL3 advances to DONE.
REQ-018 Accumulation SHALL be modulo 2^64; the true product never exceeds 2^64-1, so no carry is lost.
REQ-019 out_valid SHALL be 1 only in DONE, with c equal to the accumulator.
REQ-020 c SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 In DONE with out_ready=1, the FSM SHALL return to IDLE on the next edge.
REQ-022 Latency: handshake in cycle T gives out_valid=1 in cycle T+5; minimum initiation interval is 6 cycles.
REQ-023 in_valid outside IDLE SHALL be ignored; latched operands SHALL NOT change.
REQ-024 abort=1 in any non-IDLE state SHALL move to IDLE on the next edge and discard the result; out_valid SHALL NOT assert for that operation.
REQ-025 abort=1 in IDLE SHALL take priority over in_valid: no operand is accepted that cycle.
REQ-026 If abort=1 and out_ready=1 occur together in DONE, the block SHALL go to IDLE; the transfer is counted as complete.
REQ-027 c SHALL read 0 whenever out_valid=0.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, in_ready=1, out_valid=0, busy=0, c=0, accumulator and operand registers 0.
REQ-029 Reset mid-operation SHALL drop the operation; no out_valid follows reset release.
REQ-030 The first handshake SHALL be possible in the first clock cycle after rst_n deasserts.

Structure
REQ-031 Package vedic_pkg SHALL hold the state enum type, HALF_W, FULL_W=32 and PROD_W=64.
REQ-032 The block SHALL instantiate exactly one vedic_16x16 sub-module, fed through half-select muxes driven by the state.
REQ-033 The block SHALL have no combinational path from in_valid or out_ready to c.

Verification
REQ-034 a=3, b=5, out_ready=1 -> out_valid at T+5, c=0x000000000000000F, in_ready=1 at T+6.
REQ-035 a=b=0xFFFFFFFF -> c=0xFFFFFFFE00000001.
REQ-036 a=b=0x00010000, out_ready=0 for 3 cycles after out_valid -> c=0x0000000100000000 held stable, in_ready=0, busy=1 throughout.
REQ-037 abort=1 in MUL2 -> IDLE next cycle, out_valid stays 0; the next op a=2, b=7 gives c=14.
REQ-038 rst_n low in MUL1, then new op a=0x10000, b=0x3 -> outputs at reset values immediately, new c=0x30000.
REQ-039 in_valid held high with changing a during MUL0..DONE -> result uses only the operands latched at the handshake.
